// File: rtl/df_mon_pkg.sv
// ----------------------------------------------------------------------------
// df_mon_pkg
//   Shared types and defaults for the df_monitor slice.
//   state_t : pattern-detector FSM states. The encoding equals the number of
//             pattern bits (of 1011) matched so far, so IDLE=0 .. S1011=4.
//   CNT_W_DEF : default counter width.
// ----------------------------------------------------------------------------
package df_mon_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      S1    = 3'd1,
      S10   = 3'd2,
      S101  = 3'd3,
      S1011 = 3'd4
   } state_t;

endpackage

// File: rtl/df_monitor_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Unsigned up-counter that sticks at all-ones instead of wrapping.
//   Priority: clr > zero > inc.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset (q -> 0)
//     clr      : synchronous clear
//     zero     : synchronous return to 0 (used for run-length restart)
//     inc      : count up by one unless already all-ones
//     q        : counter value, CNT_W bits
// ----------------------------------------------------------------------------
module sat_counter
   import df_mon_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             zero,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] ONES = '1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    q <= '0;
      else if (clr)               q <= '0;
      else if (zero)              q <= '0;
      else if (inc && (q != ONES)) q <= q + CNT_W'(1);
   end

endmodule

// File: rtl/df_monitor.sv
// ----------------------------------------------------------------------------
// df_monitor
//   Consumer stage for Com_Seq outputs. Watches D for the serial pattern
//   1011 (overlap allowed) and tracks F high-run lengths.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     en        : sample enable; all state holds while low
//     clr       : synchronous clear of FSM and counters (beats en)
//     D, F      : sampled serial data and flag
//     match     : one-cycle strobe after the edge that completes 1011
//     match_cnt : saturating count of match strobes
//     f_run     : current consecutive F=1 run length, saturating
//     f_max     : longest F run since reset/clear, saturating
//     state_o   : FSM state encoding for debug
//   Every output is registered; inputs sampled at edge k show after edge k.
// ----------------------------------------------------------------------------
module df_monitor
   import df_mon_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             D,
   input  logic             F,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] f_run,
   output logic [CNT_W-1:0] f_max,
   output logic [2:0]       state_o
);

   localparam logic [CNT_W-1:0] ONES = '1;

   state_t           state_q, state_d;
   logic             sample;
   logic             hit;
   logic [CNT_W-1:0] f_run_d;

   assign sample = en & ~clr;

   // --- FSM: state register ---
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // --- FSM: next state ---
   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else if (en) begin
         unique case (state_q)
            IDLE:    state_d = D ? S1    : IDLE;
            S1:      state_d = D ? S1    : S10;
            S10:     state_d = D ? S101  : IDLE;
            S101:    state_d = D ? S1011 : S10;
            S1011:   state_d = D ? S1    : S10;   // reuse trailing "1"/"10"
            default: state_d = IDLE;
         endcase
      end
   end

   // --- FSM: outputs ---
   // hit is qualified by sample so that holding in S1011 with en low does
   // not re-fire the strobe.
   always_comb begin
      state_o = state_q;
      hit     = sample && (state_d == S1011);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) match <= 1'b0;
      else     match <= hit;
   end

   // Counter bumps on the same edge that raises match, so the count and the
   // strobe appear together.
   sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (hit),
      .zero (1'b0),
      .q    (match_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_f_run (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (sample & F),
      .zero (sample & ~F),
      .q    (f_run)
   );

   // Next f_run value, mirrored here so f_max can compare against it on the
   // same edge and never lag the run counter.
   always_comb begin
      f_run_d = f_run;
      if (clr)         f_run_d = '0;
      else if (sample) f_run_d = !F ? '0 : ((f_run == ONES) ? f_run : f_run + CNT_W'(1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  f_max <= '0;
      else if (clr)             f_max <= '0;
      else if (f_run_d > f_max) f_max <= f_run_d;
   end

endmodule

// File: tb/tb_df_monitor.sv
// ----------------------------------------------------------------------------
// tb_df_monitor
//   Drives two df_monitor instances (CNT_W=8 and CNT_W=2) with the same
//   stimulus and compares both against a reference model built on a sliding
//   window of sampled D bits and plain saturating integer arithmetic.
// ----------------------------------------------------------------------------
module tb_df_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       clr = 1'b0;
   logic       D   = 1'b0;
   logic       F   = 1'b0;

   logic       match8, match2;
   logic [7:0] cnt8, run8, max8;
   logic [1:0] cnt2, run2, max2;
   logic [2:0] st8, st2;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   int hist, hl, m_match, m_st;
   int m_cnt8, m_run8, m_max8, m_cnt2, m_run2, m_max2;

   always #5 clk = ~clk;

   df_monitor u_dut8 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .D(D), .F(F),
      .match(match8), .match_cnt(cnt8), .f_run(run8), .f_max(max8), .state_o(st8)
   );

   df_monitor #(.CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .D(D), .F(F),
      .match(match2), .match_cnt(cnt2), .f_run(run2), .f_max(max2), .state_o(st2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Detector state = length of the longest suffix of the sampled history
   // that is a prefix of 1011.
   function automatic int suffix_state();
      for (int L = 4; L > 0; L--)
         if (L <= hl && (hist & ((1 << L) - 1)) == (11 >> (4 - L))) return L;
      return 0;
   endfunction

   task automatic model_clear();
      hist = 0; hl = 0; m_match = 0; m_st = 0;
      m_cnt8 = 0; m_run8 = 0; m_max8 = 0;
      m_cnt2 = 0; m_run2 = 0; m_max2 = 0;
   endtask

   task automatic model_step(input logic d, input logic f, input logic e, input logic c);
      if (c) begin
         model_clear();
      end else if (e) begin
         hist    = ((hist << 1) | int'(d)) & 15;
         hl      = (hl < 4) ? hl + 1 : 4;
         m_match = (hl == 4 && hist == 11) ? 1 : 0;
         if (m_match != 0) begin
            m_cnt8 = sat(m_cnt8 + 1, 255);
            m_cnt2 = sat(m_cnt2 + 1, 3);
         end
         m_run8 = f ? sat(m_run8 + 1, 255) : 0;
         m_run2 = f ? sat(m_run2 + 1, 3)   : 0;
         m_max8 = imax(m_max8, m_run8);
         m_max2 = imax(m_max2, m_run2);
         m_st   = suffix_state();
      end else begin
         m_match = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".match8"}, 32'(match8), 32'(m_match));
      chk({tag, ".cnt8"},   32'(cnt8),   32'(m_cnt8));
      chk({tag, ".run8"},   32'(run8),   32'(m_run8));
      chk({tag, ".max8"},   32'(max8),   32'(m_max8));
      chk({tag, ".st8"},    32'(st8),    32'(m_st));
      chk({tag, ".match2"}, 32'(match2), 32'(m_match));
      chk({tag, ".cnt2"},   32'(cnt2),   32'(m_cnt2));
      chk({tag, ".run2"},   32'(run2),   32'(m_run2));
      chk({tag, ".max2"},   32'(max2),   32'(m_max2));
      chk({tag, ".st2"},    32'(st2),    32'(m_st));
   endtask

   // Inputs change 1 time unit after a rising edge; outputs checked 1 unit
   // after the following rising edge.
   task automatic step(input string tag, input logic d, input logic f,
                       input logic e, input logic c);
      D = d; F = f; en = e; clr = c;
      @(posedge clk); #1;
      model_step(d, f, e, c);
      check_all(tag);
   endtask

   task automatic do_clear();
      step("clr", 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      logic [15:0] pat;
      logic [6:0]  fpat;
      model_clear();
      #1;

      // Reset held for 3 cycles with random inputs
      for (int i = 0; i < 3; i++) begin
         D = 1'($urandom); F = 1'($urandom); en = 1'b1;
         @(posedge clk); #1;
         check_all("rst_hold");
      end
      rst = 1'b0;

      // Overlap: 1,0,1,1,0,1,1 -> matches after samples 4 and 7
      pat = 16'b1011011;
      for (int i = 6; i >= 0; i--) step("ovl", pat[i], 1'b0, 1'b1, 1'b0);
      chk("ovl_cnt", 32'(cnt8), 32'd2);

      // Near misses: 1,0,0,1,0,1,0,1,1 -> single match at the end
      do_clear();
      pat = 16'b100101011;
      for (int i = 8; i >= 0; i--) step("near", pat[i], 1'b0, 1'b1, 1'b0);
      chk("near_match", 32'(match8), 32'd1);
      chk("near_cnt",   32'(cnt8),   32'd1);

      // F runs: 1,1,1,0,1,1,0 -> f_run 1,2,3,0,1,2,0 ; f_max 3
      do_clear();
      fpat = 7'b1110110;
      for (int i = 6; i >= 0; i--) step("frun", 1'b0, fpat[i], 1'b1, 1'b0);
      chk("frun_max", 32'(max8), 32'd3);

      // Enable gap: 1,0,(en=0 x5),1,1 -> one match
      do_clear();
      step("gap", 1'b1, 1'b0, 1'b1, 1'b0);
      step("gap", 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step("gap_off", 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      step("gap", 1'b1, 1'b1, 1'b1, 1'b0);
      step("gap", 1'b1, 1'b1, 1'b1, 1'b0);
      chk("gap_cnt", 32'(cnt8), 32'd1);
      // en drops while in S1011: strobe falls, state holds
      step("gap_hold", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("gap_hold_st", 32'(st8), 32'd4);
      // clr beats en and D
      step("clr_en", 1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr_st", 32'(st8), 32'd0);

      // Saturation on the 2-bit instance: 5 overlapping matches, then F x6
      pat = 16'b1011011011011011;
      for (int i = 15; i >= 0; i--) step("sat", pat[i], 1'b0, 1'b1, 1'b0);
      chk("sat_cnt2", 32'(cnt2), 32'd3);
      chk("sat_cnt8", 32'(cnt8), 32'd5);
      for (int i = 0; i < 6; i++) step("satf", 1'b0, 1'b1, 1'b1, 1'b0);
      chk("sat_run2", 32'(run2), 32'd3);
      chk("sat_max2", 32'(max2), 32'd3);

      // Async reset mid-cycle, mid-pattern
      step("arst", 1'b1, 1'b1, 1'b1, 1'b0);
      step("arst", 1'b0, 1'b1, 1'b1, 1'b0);
      step("arst", 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_clear();
      check_all("arst_now");
      @(posedge clk); #1;
      rst = 1'b0;
      // partial 101 was abandoned: a following 1 must not match
      step("arst_after", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("arst_nomatch", 32'(match8), 32'd0);

      // Random stimulus against the model
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) != 0), ($urandom_range(0, 40) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
